// File: rtl/multdiv_unit.sv
// Iterative multiply/divide unit holding architectural HI/LO; optional MADD family under `MULTDIV_MADD_EN`.
// Latency: MULT/MADD commit MULT_CYCLES+1 cycles after accept, DIV after DIV_CYCLES+1; MTHI/MTLO next cycle.
// Backpressure: busy (combinational) stalls HI/LO-class instructions; starts while BUSY are ignored.
module multdiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic        dis,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULTDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      tmp_hi_q, tmp_lo_q;

    logic             accept;
    logic             multi_d;
    logic [CNT_W-1:0] cycles_d;
    logic [31:0]      tmp_hi_d, tmp_lo_d;

    logic [63:0]      prod_s, prod_u;
    logic [31:0]      a_abs, b_abs, b_abs_safe, b_safe;
    logic [31:0]      q_abs, r_abs, q_s, r_s, q_u, r_u;
    logic             div_zero;

    assign accept = start && !dis && (state_q == IDLE);

    // Full-width products; sign-extending into 64 bits makes the truncated product the signed result.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division via magnitudes so 0x80000000 / -1 wraps to 0x80000000 with zero remainder.
    // A zero divisor is replaced by 1 only to keep the divider well-defined; its result is discarded.
    assign div_zero   = (B == 32'd0);
    assign a_abs      = A[31] ? (~A + 32'd1) : A;
    assign b_abs      = B[31] ? (~B + 32'd1) : B;
    assign b_abs_safe = div_zero ? 32'd1 : b_abs;
    assign b_safe     = div_zero ? 32'd1 : B;
    assign q_abs      = a_abs / b_abs_safe;
    assign r_abs      = a_abs % b_abs_safe;
    assign q_s        = (A[31] ^ B[31]) ? (~q_abs + 32'd1) : q_abs;
    assign r_s        = A[31] ? (~r_abs + 32'd1) : r_abs;
    assign q_u        = A / b_safe;
    assign r_u        = A % b_safe;

    // Decode the opcode into the result to latch and the busy duration; divide-by-zero latches current HI/LO.
    always_comb begin
        multi_d  = 1'b0;
        cycles_d = '0;
        tmp_hi_d = hi_q;
        tmp_lo_d = lo_q;
        case (op)
            OP_MULT: begin
                multi_d  = 1'b1;
                cycles_d = CNT_W'(MULT_CYCLES);
                {tmp_hi_d, tmp_lo_d} = prod_s;
            end
            OP_MULTU: begin
                multi_d  = 1'b1;
                cycles_d = CNT_W'(MULT_CYCLES);
                {tmp_hi_d, tmp_lo_d} = prod_u;
            end
            OP_DIV: begin
                multi_d  = 1'b1;
                cycles_d = CNT_W'(DIV_CYCLES);
                if (!div_zero) begin
                    tmp_hi_d = r_s;
                    tmp_lo_d = q_s;
                end
            end
            OP_DIVU: begin
                multi_d  = 1'b1;
                cycles_d = CNT_W'(DIV_CYCLES);
                if (!div_zero) begin
                    tmp_hi_d = r_u;
                    tmp_lo_d = q_u;
                end
            end
`ifdef MULTDIV_MADD_EN
            OP_MADD: begin
                multi_d  = 1'b1;
                cycles_d = CNT_W'(MULT_CYCLES);
                {tmp_hi_d, tmp_lo_d} = {hi_q, lo_q} + prod_s;
            end
            OP_MADDU: begin
                multi_d  = 1'b1;
                cycles_d = CNT_W'(MULT_CYCLES);
                {tmp_hi_d, tmp_lo_d} = {hi_q, lo_q} + prod_u;
            end
            OP_MSUB: begin
                multi_d  = 1'b1;
                cycles_d = CNT_W'(MULT_CYCLES);
                {tmp_hi_d, tmp_lo_d} = {hi_q, lo_q} - prod_s;
            end
            OP_MSUBU: begin
                multi_d  = 1'b1;
                cycles_d = CNT_W'(MULT_CYCLES);
                {tmp_hi_d, tmp_lo_d} = {hi_q, lo_q} - prod_u;
            end
`endif
            default: ;
        endcase
    end

    // Stall the pipeline both while iterating and in the cycle a multi-cycle op is accepted.
    assign busy = (state_q == BUSY) || (accept && multi_d);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // IDLE/BUSY controller: accept, count down, commit the latched result on the last busy cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (multi_d) begin
                            tmp_hi_q <= tmp_hi_d;
                            tmp_lo_q <= tmp_lo_d;
                            cnt_q    <= cycles_d;
                            state_q  <= BUSY;
                        end else if (op == OP_MTHI) begin
                            hi_q <= A;
                        end else if (op == OP_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= tmp_hi_q;
                        lo_q    <= tmp_lo_q;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases followed by randomized ops vs an arithmetic model.
// Each op is driven for one cycle, then busy is sampled every cycle until it drops.
// HI/LO are then compared with the model; the bench never starts an op while one is in flight.
module tb_multdiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic        dis;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    bit          in_flight = 1'b0;

    multdiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .dis   (dis),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    // The pipeline never issues a start while the unit is iterating.
    always @(posedge clk) begin
        if (reset && in_flight) begin
            assert (!start) else $error("start issued while unit busy");
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: returns whether the op runs multi-cycle and the {HI,LO} it leaves behind.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit d, output bit multi, output int cycles,
                         output logic [31:0] nhi, output logic [31:0] nlo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     acc, ps, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        ps = 64'(sa * sb);
        pu = 64'(ua * ub);
        acc = {m_hi, m_lo};
        multi = 1'b0;
        cycles = 0;
        nhi = m_hi;
        nlo = m_lo;
        if (!d) begin
            case (o)
                4'd1: begin multi = 1; cycles = MC; {nhi, nlo} = ps; end
                4'd2: begin multi = 1; cycles = MC; {nhi, nlo} = pu; end
                4'd3: begin
                    multi = 1; cycles = DC;
                    if (b != 0) begin
                        sq = sa / sb;
                        sr = sa % sb;
                        nlo = sq[31:0];
                        nhi = sr[31:0];
                    end
                end
                4'd4: begin
                    multi = 1; cycles = DC;
                    if (b != 0) begin
                        nlo = 32'(ua / ub);
                        nhi = 32'(ua % ub);
                    end
                end
                4'd5: nhi = a;
                4'd6: nlo = a;
`ifdef MULTDIV_MADD_EN
                4'd7:  begin multi = 1; cycles = MC; {nhi, nlo} = acc + ps; end
                4'd8:  begin multi = 1; cycles = MC; {nhi, nlo} = acc + pu; end
                4'd9:  begin multi = 1; cycles = MC; {nhi, nlo} = acc - ps; end
                4'd10: begin multi = 1; cycles = MC; {nhi, nlo} = acc - pu; end
`endif
                default: ;
            endcase
        end
    endtask

    // Issue one op for one cycle, measure the busy window, then check HI/LO against the model.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit d);
        bit          multi;
        int          cycles, n;
        logic [31:0] nhi, nlo;
        model(o, a, b, d, multi, cycles, nhi, nlo);
        @(posedge clk);
        #1;
        start = 1'b1; op = o; A = a; B = b; dis = d;
        @(negedge clk);
        chk({tag, "_busy0"}, 64'(busy), 64'(multi));
        n = busy ? 1 : 0;
        @(posedge clk);
        #1;
        start = 1'b0; dis = 1'b0; op = 4'd0;
        in_flight = multi;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        in_flight = 1'b0;
        chk({tag, "_busylen"}, 64'(n), 64'(multi ? cycles + 1 : 0));
        m_hi = nhi;
        m_lo = nlo;
        chk({tag, "_hi"}, 64'(HI), 64'(m_hi));
        chk({tag, "_lo"}, 64'(LO), 64'(m_lo));
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        bit          rd;
        int          n;

        reset = 1'b0; start = 1'b0; op = 4'd0; dis = 1'b0; A = '0; B = '0;
        #23;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("mult_hi_c", 64'(HI), 64'hFFFFFFFF);
        chk("mult_lo_c", 64'(LO), 64'hFFFFFFFA);
        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("multu_hi_c", 64'(HI), 64'hFFFFFFFE);
        chk("multu_lo_c", 64'(LO), 64'h00000001);
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_lo_c", 64'(LO), 64'hFFFFFFFD);
        chk("div_hi_c", 64'(HI), 64'hFFFFFFFF);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 1'b0);
        chk("divu0_hold", 64'({HI, LO}), 64'hFFFFFFFF_FFFFFFFD);
        run_op("div0", 4'd3, 32'd9, 32'd0, 1'b0);
        run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("divovf_c", 64'({HI, LO}), 64'h00000000_80000000);
        run_op("mthi", 4'd5, 32'h12345678, 32'd0, 1'b0);
        chk("mthi_c", 64'(HI), 64'h12345678);
        run_op("mthi_dis", 4'd5, 32'hDEADBEEF, 32'd0, 1'b1);
        chk("mthi_dis_c", 64'(HI), 64'h12345678);
        run_op("mult_dis", 4'd1, 32'd1234, 32'd5678, 1'b1);
        run_op("nop15", 4'd15, 32'd3, 32'd4, 1'b0);

        run_op("mthi0", 4'd5, 32'd0, 32'd0, 1'b0);
        run_op("mtlo1", 4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
        run_op("maddu", 4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MULTDIV_MADD_EN
        chk("maddu_c", 64'({HI, LO}), 64'h00000001_00000000);
`else
        chk("maddu_c", 64'({HI, LO}), 64'h00000000_FFFFFFFF);
`endif

        // Reset mid-MULT: everything clears at once, no commit afterwards.
        @(posedge clk);
        #1;
        start = 1'b1; op = 4'd1; A = 32'd7; B = 32'd9; dis = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'd0;
        in_flight = 1'b1;
        n = 0;
        while (n < 3) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        in_flight = 1'b0;
        #1;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_hilo", 64'({HI, LO}), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("rstmid_nocommit", 64'({HI, LO}), 64'd0);
        run_op("mtlo_a5", 4'd6, 32'hA5A5A5A5, 32'd0, 1'b0);
        chk("mtlo_a5_c", 64'(LO), 64'hA5A5A5A5);

        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            rd = ($urandom_range(0, 4) == 0);
            run_op("rand", ro, ra, rb, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
